// File: rtl/code_lock_ctrl.sv
// Combination-lock controller: buffers keypad digits, checks them against CODE on ENTER,
// and drives the unlock LED, progress LEDs, failure pulse and lockout timing.
module code_lock_ctrl #(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int          TIMEOUT_TICKS = 250,
    parameter int          UNLOCK_TICKS  = 150,
    parameter int          MAX_FAILS     = 3,
    parameter int          LOCKOUT_TICKS = 500
) (
    input  logic        pulse_50Mhz,
    input  logic        rst,
    input  logic        pulse_50Hz,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [3:0]  led,
    output logic        led_g,
    output logic        err,
    output logic        lockout
);

    localparam int MAX_TICKS_A = (TIMEOUT_TICKS > UNLOCK_TICKS) ? TIMEOUT_TICKS : UNLOCK_TICKS;
    localparam int MAX_TICKS   = (MAX_TICKS_A > LOCKOUT_TICKS) ? MAX_TICKS_A : LOCKOUT_TICKS;
    localparam int TW          = $clog2(MAX_TICKS + 1);
    localparam int FW          = $clog2(MAX_FAILS + 1);

    localparam logic [TW-1:0] TIMEOUT_T  = TW'(TIMEOUT_TICKS);
    localparam logic [TW-1:0] UNLOCK_T   = TW'(UNLOCK_TICKS);
    localparam logic [TW-1:0] LOCKOUT_T  = TW'(LOCKOUT_TICKS);
    localparam logic [TW-1:0] TICK_SAT   = TW'(MAX_TICKS);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_UNLOCKED,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [15:0]   r_digits;
    logic [15:0]   w_next_digits;
    logic [2:0]    r_count;
    logic [2:0]    w_next_count;
    logic [FW-1:0] r_fail_cnt;
    logic [FW-1:0] w_next_fail_cnt;
    logic [FW-1:0] w_fail_inc;
    logic [TW-1:0] r_tick_cnt;
    logic          w_key_accepted;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync_prev;
    logic [2:0]    r_sync_vld;
    logic          w_tick;

    logic          w_is_digit;
    logic          w_is_clear;
    logic          w_is_enter;

    logic [3:0]    r_led;
    logic          r_led_g;
    logic          r_err;
    logic          r_lockout;
    logic [3:0]    w_led;
    logic          w_led_g;
    logic          w_err;
    logic          w_lockout;

    // r_sync_vld masks the edge detector until the synchroniser and its history hold real samples,
    // so an input that is already high when reset releases does not count as a tick.
    always_ff @(posedge pulse_50Mhz or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_sync_vld  <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value of its source.
            r_sync1     <= pulse_50Hz;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_sync_vld  <= {r_sync_vld[1:0], 1'b1};
        end
    end

    assign w_tick     = r_sync2 & ~r_sync_prev & r_sync_vld[2];
    assign w_is_digit = key_valid && (key_code <= 4'd9);
    assign w_is_clear = key_valid && (key_code == 4'hE);
    assign w_is_enter = key_valid && (key_code == 4'hF);
    assign w_fail_inc = r_fail_cnt + FW'(1);

    always_ff @(posedge pulse_50Mhz or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_digits   <= 16'h0000;
            r_count    <= 3'd0;
            r_fail_cnt <= '0;
            r_tick_cnt <= '0;
            r_led      <= 4'b0000;
            r_led_g    <= 1'b0;
            r_err      <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_digits   <= w_next_digits;
            r_count    <= w_next_count;
            r_fail_cnt <= w_next_fail_cnt;
            if ((r_state != w_next_state) || w_key_accepted)
                r_tick_cnt <= '0;
            else if (w_tick && (r_tick_cnt != TICK_SAT))
                r_tick_cnt <= r_tick_cnt + TW'(1);
            r_led      <= w_led;
            r_led_g    <= w_led_g;
            r_err      <= w_err;
            r_lockout  <= w_lockout;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_next_state    = r_state;
        w_next_digits   = r_digits;
        w_next_count    = r_count;
        w_next_fail_cnt = r_fail_cnt;
        w_key_accepted  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_digit) begin
                    w_next_digits  = {r_digits[11:0], key_code};
                    w_next_count   = 3'd1;
                    w_next_state   = S_ENTRY;
                    w_key_accepted = 1'b1;
                end
            end
            S_ENTRY: begin
                // A key in the same cycle as the timeout tick takes priority.
                if (w_is_digit && (r_count < 3'd4)) begin
                    w_next_digits  = {r_digits[11:0], key_code};
                    w_next_count   = r_count + 3'd1;
                    w_key_accepted = 1'b1;
                end else if (w_is_clear) begin
                    w_next_state   = S_IDLE;
                    w_next_digits  = 16'h0000;
                    w_next_count   = 3'd0;
                    w_key_accepted = 1'b1;
                end else if (w_is_enter) begin
                    w_next_count   = 3'd0;
                    w_key_accepted = 1'b1;
                    if (r_count == 3'd4) begin
                        w_next_state = S_CHECK;
                    end else begin
                        w_next_state  = S_FAIL;
                        w_next_digits = 16'h0000;
                    end
                end else if (r_tick_cnt == TIMEOUT_T) begin
                    w_next_state  = S_IDLE;
                    w_next_digits = 16'h0000;
                    w_next_count  = 3'd0;
                end
            end
            S_CHECK: begin
                if (r_digits == CODE) begin
                    w_next_state    = S_UNLOCKED;
                    w_next_fail_cnt = '0;
                end else begin
                    w_next_state  = S_FAIL;
                    w_next_digits = 16'h0000;
                end
            end
            S_UNLOCKED: begin
                if (w_is_clear) begin
                    w_next_state   = S_IDLE;
                    w_next_digits  = 16'h0000;
                    w_key_accepted = 1'b1;
                end else if (r_tick_cnt == UNLOCK_T) begin
                    w_next_state  = S_IDLE;
                    w_next_digits = 16'h0000;
                end
            end
            S_FAIL: begin
                w_next_digits   = 16'h0000;
                w_next_fail_cnt = w_fail_inc;
                w_next_state    = (w_fail_inc == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
            end
            S_LOCKOUT: begin
                if (r_tick_cnt == LOCKOUT_T) begin
                    w_next_state    = S_IDLE;
                    w_next_fail_cnt = '0;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_digits = 16'h0000;
                w_next_count  = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state register.
    always_comb begin
        w_led     = 4'b0000;
        w_led_g   = (w_next_state == S_UNLOCKED);
        w_err     = (w_next_state == S_FAIL);
        w_lockout = (w_next_state == S_LOCKOUT);
        case (w_next_state)
            S_IDLE, S_ENTRY: begin
                case (w_next_count)
                    3'd0:    w_led = 4'b0000;
                    3'd1:    w_led = 4'b0001;
                    3'd2:    w_led = 4'b0011;
                    3'd3:    w_led = 4'b0111;
                    default: w_led = 4'b1111;
                endcase
            end
            S_UNLOCKED: w_led = 4'b1111;
            default:    w_led = 4'b0000;
        endcase
    end

    assign digits  = r_digits;
    assign led     = r_led;
    assign led_g   = r_led_g;
    assign err     = r_err;
    assign lockout = r_lockout;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios followed by random key/tick traffic,
// all checked against a transaction-level model of the lock's rules.
module tb_code_lock_ctrl;

    localparam logic [15:0] CODE = 16'h1234;
    localparam int TO = 4;
    localparam int UN = 3;
    localparam int LO = 5;
    localparam int MF = 3;

    logic        clk;
    logic        rst;
    logic        pulse_50Hz;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [3:0]  led;
    logic        led_g;
    logic        err;
    logic        lockout;

    code_lock_ctrl #(
        .CODE(CODE), .TIMEOUT_TICKS(TO), .UNLOCK_TICKS(UN),
        .MAX_FAILS(MF), .LOCKOUT_TICKS(LO)
    ) dut (
        .pulse_50Mhz(clk), .rst(rst), .pulse_50Hz(pulse_50Hz),
        .key_valid(key_valid), .key_code(key_code),
        .digits(digits), .led(led), .led_g(led_g), .err(err), .lockout(lockout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: the digits typed so far, the mode flags and the ticks seen in the current mode.
    int q[$];
    bit m_unlocked;
    bit m_locked;
    int m_fails;
    int m_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_digits();
        logic [15:0] v;
        v = 16'h0000;
        foreach (q[i]) v = {v[11:0], 4'(q[i])};
        return v;
    endfunction

    function automatic logic [3:0] m_led();
        if (m_locked) return 4'b0000;
        if (m_unlocked) return 4'b1111;
        return 4'((1 << q.size()) - 1);
    endfunction

    function automatic logic [3:0] code_nib(input int idx);
        return 4'(CODE >> (12 - 4 * idx));
    endfunction

    task automatic m_reset();
        q.delete();
        m_unlocked = 1'b0;
        m_locked   = 1'b0;
        m_fails    = 0;
        m_t        = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"}, 32'(digits), 32'(m_digits()));
        check({tag, ".led"}, 32'(led), 32'(m_led()));
        check({tag, ".led_g"}, 32'(led_g), 32'(m_unlocked));
        check({tag, ".err"}, 32'(err), 32'd0);
        check({tag, ".lockout"}, 32'(lockout), 32'(m_locked));
    endtask

    // Called just after a falling edge; returns just after a falling edge with all effects settled.
    task automatic press_key(input logic [3:0] k);
        int outcome;  // 0 plain key, 1 correct code, 2 wrong code, 3 short entry
        outcome = 0;
        if (!m_locked) begin
            if (k <= 4'd9) begin
                if (!m_unlocked && q.size() < 4) begin
                    q.push_back(int'(k));
                    m_t = 0;
                end
            end else if (k == 4'hE) begin
                if (m_unlocked) begin
                    m_unlocked = 1'b0;
                    q.delete();
                    m_t = 0;
                end else if (q.size() > 0) begin
                    q.delete();
                    m_t = 0;
                end
            end else if (k == 4'hF && !m_unlocked && q.size() > 0) begin
                if (q.size() < 4) outcome = 3;
                else if (m_digits() == CODE) outcome = 1;
                else outcome = 2;
            end
        end
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        if (outcome == 0) begin
            check_all("key");
        end else begin
            check("enter+1.err", 32'(err), 32'(outcome == 3));
            check("enter+1.led_g", 32'(led_g), 32'd0);
            @(negedge clk);
            check("enter+2.err", 32'(err), 32'(outcome == 2));
            check("enter+2.led_g", 32'(led_g), 32'(outcome == 1));
            @(negedge clk);
            if (outcome == 1) begin
                m_unlocked = 1'b1;
                m_fails    = 0;
            end else begin
                q.delete();
                m_fails++;
                if (m_fails == MF) begin
                    m_locked = 1'b1;
                    m_fails  = 0;
                end
            end
            m_t = 0;
            check_all("enter+3");
        end
    endtask

    task automatic model_tick();
        if (m_locked) begin
            m_t++;
            if (m_t == LO) begin
                m_locked = 1'b0;
                m_t = 0;
            end
        end else if (m_unlocked) begin
            m_t++;
            if (m_t == UN) begin
                m_unlocked = 1'b0;
                q.delete();
                m_t = 0;
            end
        end else if (q.size() > 0) begin
            m_t++;
            if (m_t == TO) begin
                q.delete();
                m_t = 0;
            end
        end
    endtask

    task automatic do_tick();
        pulse_50Hz = 1'b1;
        repeat (4) @(negedge clk);
        pulse_50Hz = 1'b0;
        repeat (4) @(negedge clk);
        model_tick();
        check_all("tick");
    endtask

    initial begin
        rst        = 1'b1;
        pulse_50Hz = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        @(negedge clk);

        // Correct code, then the unlock window expires.
        press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
        check("code.digits", 32'(digits), 32'h1234);
        check("code.led", 32'(led), 32'hF);
        press_key(4'hF);
        repeat (UN) do_tick();
        check("unlock_end.led_g", 32'(led_g), 32'd0);

        // Three wrong codes lock the keypad; keys are ignored until the lockout expires.
        repeat (MF) begin
            press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h5);
            press_key(4'hF);
        end
        check("lock.lockout", 32'(lockout), 32'd1);
        press_key(4'h1);
        repeat (LO) do_tick();
        check("lock_end.lockout", 32'(lockout), 32'd0);

        // Inactivity timeout during entry.
        press_key(4'h9); press_key(4'h8);
        repeat (TO) do_tick();
        check("timeout.digits", 32'(digits), 32'h0);

        // A fifth digit is ignored, then CLEAR empties the buffer.
        press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4); press_key(4'h5);
        check("fifth.digits", 32'(digits), 32'h1234);
        press_key(4'hE);

        // Short entry fails.
        press_key(4'h1); press_key(4'h2); press_key(4'hF);

        // Key coincident with a tick: the key wins and the timeout restarts.
        press_key(4'h9);
        repeat (TO - 1) do_tick();
        pulse_50Hz = 1'b1;
        @(negedge clk);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h7;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        q.push_back(7);
        m_t = 0;
        repeat (2) @(negedge clk);
        pulse_50Hz = 1'b0;
        repeat (4) @(negedge clk);
        check_all("coincident");
        repeat (TO) do_tick();

        // Reset mid-entry clears outputs at once; a high tick input at release is not a tick.
        press_key(4'h1); press_key(4'h2);
        check("pre_rst.digits", 32'(digits), 32'h0012);
        pulse_50Hz = 1'b1;
        rst = 1'b1;
        #1;
        m_reset();
        check_all("rst_async");
        @(negedge clk);
        rst = 1'b0;
        press_key(4'h3);
        pulse_50Hz = 1'b0;
        repeat (4) @(negedge clk);
        check_all("post_rst");
        repeat (TO) do_tick();

        // Random traffic, biased toward the correct code so unlocks also occur.
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                if (q.size() < 4 && $urandom_range(0, 3) != 0) press_key(code_nib(q.size()));
                else press_key(4'($urandom_range(0, 9)));
            end else if (op == 5) begin
                press_key(4'hF);
            end else if (op == 6) begin
                press_key(4'hE);
            end else if (op == 7) begin
                press_key(4'($urandom_range(10, 13)));
            end else begin
                do_tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
